// File: rtl/sliding_window_agg.sv
`default_nettype none
// ============================================================================
//  Module   : sliding_window_agg
//  Purpose  : Event-driven sliding-window aggregator. Signed samples are
//             folded into a ring of NUM_BUCKETS time buckets, one bucket per
//             period of PERIOD_CYCLES enabled cycles. At every period tick the
//             aggregate (sum / count / max / min) over the whole ring is
//             registered out, the ring advances and the oldest bucket is
//             cleared to the identity value.
//  Ports    : clk        - system clock, rising edge
//             rst        - asynchronous active-high reset
//             en         - global enable; low holds all state
//             data_in    - signed sample
//             data_valid - sample present this cycle
//             win_out    - registered window aggregate (signed)
//             win_valid  - one-cycle pulse, win_out updated
//             win_full   - NUM_BUCKETS periods completed since reset
//             bucket_idx - index of the bucket currently accumulating
//  Revision : 1.0 - initial release
// ============================================================================
module sliding_window_agg #(
  parameter int DATA_W        = 64,
  parameter int NUM_BUCKETS   = 2,
  parameter int PERIOD_CYCLES = 10,
  parameter int MODE          = 0,
  localparam int IDX_W        = (NUM_BUCKETS > 1) ? $clog2(NUM_BUCKETS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic [DATA_W-1:0] win_out,
  output logic              win_valid,
  output logic              win_full,
  output logic [IDX_W-1:0]  bucket_idx
);

  localparam int c_TMR_W  = $clog2(PERIOD_CYCLES);
  localparam int c_FILL_W = $clog2(NUM_BUCKETS + 1);

  localparam logic [c_TMR_W-1:0]  c_TMR_LAST  = c_TMR_W'(PERIOD_CYCLES - 1);
  localparam logic [IDX_W-1:0]    c_IDX_LAST  = IDX_W'(NUM_BUCKETS - 1);
  localparam logic [c_FILL_W-1:0] c_FILL_FULL = c_FILL_W'(NUM_BUCKETS);

  // Identity element of the selected reduction: most negative value for max,
  // most positive value for min, zero for sum and count.
  localparam logic [DATA_W-1:0] c_IDENT =
      (MODE == 2) ? {1'b1, {(DATA_W-1){1'b0}}} :
      (MODE == 3) ? {1'b0, {(DATA_W-1){1'b1}}} :
                    {DATA_W{1'b0}};

  // Combines two partial aggregates (bucket-to-bucket). Count buckets hold
  // counts, so they combine by addition just like sum buckets.
  function automatic logic [DATA_W-1:0] f_comb(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (MODE)
      2:       r = ($signed(b) > $signed(a)) ? b : a;
      3:       r = ($signed(b) < $signed(a)) ? b : a;
      default: r = a + b;
    endcase
    return r;
  endfunction

  // Folds one raw sample into a bucket. Count ignores the sample value.
  function automatic logic [DATA_W-1:0] f_op(input logic [DATA_W-1:0] acc,
                                             input logic [DATA_W-1:0] smp);
    logic [DATA_W-1:0] r;
    if (MODE == 1) r = acc + DATA_W'(1);
    else           r = f_comb(acc, smp);
    return r;
  endfunction

  logic [DATA_W-1:0]   r_bucket [NUM_BUCKETS];
  logic [c_TMR_W-1:0]  r_tmr;
  logic [IDX_W-1:0]    r_idx;
  logic [c_FILL_W-1:0] r_fill;
  logic [DATA_W-1:0]   r_win_out;
  logic                r_win_valid;

  logic                w_tick;
  logic                w_sample;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [c_FILL_W-1:0] w_fill_nxt;
  logic [DATA_W-1:0]   w_cur_old;
  logic [DATA_W-1:0]   w_cur_new;
  logic [DATA_W-1:0]   w_agg;

  assign w_tick     = en && (r_tmr == c_TMR_LAST);
  assign w_sample   = en && data_valid;
  assign w_idx_nxt  = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
  assign w_fill_nxt = (r_fill == c_FILL_FULL) ? r_fill : r_fill + 1'b1;

  // Current bucket read through a compare-select so the index never has to
  // address beyond the ring when NUM_BUCKETS is not a power of two.
  always_comb begin
    w_cur_old = c_IDENT;
    for (int i = 0; i < NUM_BUCKETS; i++) begin
      if (IDX_W'(i) == r_idx) w_cur_old = r_bucket[i];
    end
  end

  assign w_cur_new = w_sample ? f_op(w_cur_old, data_in) : w_cur_old;

  // Window reduction. The current bucket enters with this cycle's sample
  // already folded in, so an event on the tick cycle lands in the closing
  // period.
  always_comb begin
    w_agg = c_IDENT;
    for (int i = 0; i < NUM_BUCKETS; i++) begin
      w_agg = f_comb(w_agg, (IDX_W'(i) == r_idx) ? w_cur_new : r_bucket[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BUCKETS; i++) r_bucket[i] <= c_IDENT;
      r_tmr       <= '0;
      r_idx       <= '0;
      r_fill      <= '0;
      r_win_out   <= '0;
      r_win_valid <= 1'b0;
    end else begin
      r_win_valid <= 1'b0;
      if (en) begin
        r_tmr <= w_tick ? '0 : r_tmr + 1'b1;
        // Eviction wins over accumulation: with a single bucket the closing
        // and the newly opened bucket are the same storage.
        for (int i = 0; i < NUM_BUCKETS; i++) begin
          if (w_tick && (IDX_W'(i) == w_idx_nxt))
            r_bucket[i] <= c_IDENT;
          else if (IDX_W'(i) == r_idx)
            r_bucket[i] <= w_cur_new;
        end
        if (w_tick) begin
          r_idx       <= w_idx_nxt;
          r_win_out   <= w_agg;
          r_win_valid <= 1'b1;
          r_fill      <= w_fill_nxt;
        end
      end
    end
  end

  assign win_out    = r_win_out;
  // A pending pulse is suppressed while the block is disabled.
  assign win_valid  = r_win_valid && en;
  assign win_full   = (r_fill == c_FILL_FULL);
  assign bucket_idx = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_sliding_window_agg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sliding_window_agg
//  Purpose  : Self-checking bench for sliding_window_agg. Five instances share
//             one stimulus stream: sum/count/max/min with two buckets and a
//             single-bucket sum, all with 5-cycle periods. A sample-history
//             model recomputes every window from the raw events.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sliding_window_agg;

  localparam int c_NI  = 5;
  localparam int c_PER = 5;
  localparam logic signed [63:0] c_MAX = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [63:0] c_MIN = 64'sh8000_0000_0000_0000;

  logic              clk;
  logic              rst;
  logic              en;
  logic [63:0]       data_in;
  logic              data_valid;
  logic [63:0]       wo [c_NI];
  logic              wv [c_NI];
  logic              wf [c_NI];
  logic [0:0]        bi [c_NI];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < c_NI; g++) begin : g_dut
    sliding_window_agg #(
      .DATA_W       (64),
      .NUM_BUCKETS  ((g == 4) ? 1 : 2),
      .PERIOD_CYCLES(c_PER),
      .MODE         ((g == 4) ? 0 : g)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .data_in   (data_in),
      .data_valid(data_valid),
      .win_out   (wo[g]),
      .win_valid (wv[g]),
      .win_full  (wf[g]),
      .bucket_idx(bi[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model: raw event history ----------------
  typedef struct {
    int                 per;
    logic signed [63:0] v;
  } samp_t;

  samp_t              hist[$];
  int                 m_per;
  int                 m_tmr;
  int                 m_done;
  bit                 m_pend;
  logic signed [63:0] m_out [c_NI];

  function automatic int mode_of(int i);
    return (i == 4) ? 0 : i;
  endfunction

  function automatic int nb_of(int i);
    return (i == 4) ? 1 : 2;
  endfunction

  // Aggregate of every sample whose period lies in the last n periods
  // ending with period p.
  function automatic logic signed [63:0] window(int mode, int n, int p);
    logic signed [63:0] r;
    r = (mode == 2) ? c_MIN : (mode == 3) ? c_MAX : 64'sd0;
    foreach (hist[k]) begin
      if (hist[k].per > p - n && hist[k].per <= p) begin
        case (mode)
          0: r = r + hist[k].v;
          1: r = r + 64'sd1;
          2: if (hist[k].v > r) r = hist[k].v;
          default: if (hist[k].v < r) r = hist[k].v;
        endcase
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_per  = 0;
    m_tmr  = 0;
    m_done = 0;
    m_pend = 0;
    for (int i = 0; i < c_NI; i++) m_out[i] = 64'sd0;
  endtask

  task automatic model_step();
    if (en) begin
      if (data_valid) hist.push_back('{m_per, $signed(data_in)});
      if (m_tmr == c_PER - 1) begin
        for (int i = 0; i < c_NI; i++) m_out[i] = window(mode_of(i), nb_of(i), m_per);
        m_pend = 1;
        m_per++;
        m_done++;
        m_tmr = 0;
      end else begin
        m_tmr++;
        m_pend = 0;
      end
    end else begin
      m_pend = 0;
    end
  endtask

  task automatic chk(input string nm, input int inst,
                     input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0d exp=%0d at %0t", nm, inst, got, exp, $time);
    end
  endtask

  // Every cycle: compare outputs (sampled mid-cycle) with the model, then
  // advance the model with the inputs that the next rising edge will see.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      for (int i = 0; i < c_NI; i++) begin
        chk("win_out",    i, $signed(wo[i]), m_out[i]);
        chk("win_valid",  i, 64'(wv[i]), 64'(m_pend && en));
        chk("win_full",   i, 64'(wf[i]), 64'(m_done >= nb_of(i)));
        chk("bucket_idx", i, 64'(bi[i]), 64'(m_per % nb_of(i)));
      end
      if (!rst) model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic e, input logic v, input logic signed [63:0] d);
    @(posedge clk);
    #2;
    en         = e;
    data_valid = v;
    data_in    = d;
  endtask

  task automatic smp(input logic signed [63:0] d);
    drive(1'b1, 1'b1, d);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, 64'sd0);
  endtask

  // Consume the first cycle of a period and look at the fresh window.
  task automatic after_tick();
    idle(1);
    @(negedge clk);
  endtask

  task automatic win(input int i, input logic signed [63:0] v, input logic full);
    chk("lit_valid", i, 64'(wv[i]), 64'sd1);
    chk("lit_out",   i, $signed(wo[i]), v);
    chk("lit_full",  i, 64'(wf[i]), 64'(full));
  endtask

  // Asynchronous assertion between edges; release leaves en low for one
  // cycle so the next driven cycle is the first cycle of period 0.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst        = 1'b1;
    data_valid = 1'b0;
    #1;
    chk("rst_out",  0, $signed(wo[0]), 64'sd0);
    chk("rst_full", 0, 64'(wf[0]), 64'sd0);
    chk("rst_idx",  0, 64'(bi[0]), 64'sd0);
    chk("rst_vld",  0, 64'(wv[0]), 64'sd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    en  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; data_valid = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // Sum over two periods, eviction of period 0
    do_reset();
    smp(1); smp(2); smp(3); idle(2);
    after_tick();
    win(0, 6, 0); win(4, 6, 1); win(1, 3, 0);
    chk("lit_idx", 0, 64'(bi[0]), 64'sd1);
    smp(4); idle(3);
    after_tick();
    win(0, 10, 1); win(4, 4, 1);
    chk("lit_idx", 0, 64'(bi[0]), 64'sd0);
    idle(4);
    after_tick();
    win(0, 4, 1); win(4, 0, 1); win(1, 1, 1);
    idle(1);
    @(negedge clk);
    chk("lit_pulse_end", 0, 64'(wv[0]), 64'sd0);

    // Sample on the tick cycle, then async reset in period 1 and restart
    do_reset();
    idle(4); smp(5);
    after_tick();
    win(0, 5, 0); win(1, 1, 0); win(2, 5, 0); win(3, 5, 0); win(4, 5, 1);
    idle(2);
    do_reset();
    smp(9); idle(4);
    after_tick();
    win(0, 9, 0);

    // Max / min / count, windows draining to identity
    do_reset();
    smp(-3); smp(7); smp(2); idle(2);
    after_tick();
    win(2, 7, 0); win(3, -3, 0); win(1, 3, 0); win(0, 6, 0);
    idle(4);
    after_tick();
    win(2, 7, 1);
    idle(4);
    after_tick();
    win(2, c_MIN, 1); win(3, c_MAX, 1); win(1, 0, 1); win(0, 0, 1);

    // Count across two periods
    do_reset();
    smp(10); smp(20); smp(30); smp(40); idle(1);
    after_tick();
    win(1, 4, 0); win(0, 100, 0);
    smp(1); idle(3);
    after_tick();
    win(1, 5, 1);

    // Sum wrap-around
    do_reset();
    smp(c_MAX); smp(1); idle(3);
    after_tick();
    win(0, c_MIN, 0); win(4, c_MIN, 1);

    // Enable freeze: tick slips by 3 cycles, gated samples ignored
    do_reset();
    smp(1);
    drive(1'b0, 1'b1, 64'sd100); drive(1'b0, 1'b1, 64'sd100); drive(1'b0, 1'b1, 64'sd100);
    smp(2); idle(1);
    @(negedge clk);
    chk("lit_no_early_tick", 0, 64'(wv[0]), 64'sd0);
    idle(2);
    after_tick();
    win(0, 3, 0);
    idle(4);
    drive(1'b0, 1'b0, 64'sd0);
    @(negedge clk);
    chk("lit_vld_gated", 0, 64'(wv[0]), 64'sd0);
    idle(2);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/sliding_window_agg.md
Name: sliding_window_agg

Overview:
- Parametrised successor of the monitor's fixed two-bucket sliding-window stage.
- Accepts event-based signed samples, accumulates them into a ring of time buckets, and emits a periodic aggregate over the last NUM_BUCKETS periods.
- Aggregation mode is selectable (sum, count, max, min). Sits between the input event queue and the periodic output streams of the generated monitor.

Parameters:
- DATA_W, 64, width of samples and aggregate (signed two's complement)
- NUM_BUCKETS, 2, window length in periods (>=1)
- PERIOD_CYCLES, 10, enabled clock cycles per period (>=2)
- MODE, 0, aggregate: 0 sum, 1 count, 2 max, 3 min

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- en  in  1  global enable; when low, the block holds all state
- data_in  in  DATA_W  signed sample
- data_valid  in  1  sample present this cycle (single-cycle pulse per event)
- win_out  out  DATA_W  aggregate over the window, signed
- win_valid  out  1  one-cycle pulse: win_out updated
- win_full  out  1  high once NUM_BUCKETS periods have completed since reset
- bucket_idx  out  clog2(NUM_BUCKETS) (min 1)  index of the bucket currently accumulating

Behaviour:
- Identity value per mode: sum/count 0; max -2^(DATA_W-1); min 2^(DATA_W-1)-1.
- Reset (async assert, released synchronously to clk): all buckets = identity, timer = 0, bucket_idx = 0, win_out = 0, win_valid = 0, win_full = 0, fill counter = 0.
- All state advances only in cycles with en=1. With en=0: timer frozen, data_valid ignored, win_valid = 0, other outputs hold.
- Timer: counts 0..PERIOD_CYCLES-1. The tick cycle is the enabled cycle in which timer == PERIOD_CYCLES-1; the timer then wraps to 0.
- Accumulate: in an enabled cycle with data_valid=1, the current bucket becomes op(bucket, data_in).
  - sum: add modulo 2^DATA_W (wraps, no saturation).
  - count: +1 modulo 2^DATA_W; data_in is ignored.
  - max/min: signed compare.
- Tick cycle:
  - The aggregate is computed over all buckets, with the current bucket including any sample arriving in the same cycle (a simultaneous event belongs to the closing period).
  - The aggregate is registered into win_out; win_valid = 1 on the following cycle (latency 1 from the tick cycle). win_valid is low in all other cycles.
  - bucket_idx advances modulo NUM_BUCKETS. The newly selected bucket (the oldest) is cleared to identity in the same edge, evicting its contents.
  - Fill counter increments and saturates at NUM_BUCKETS; win_full = (fill == NUM_BUCKETS), updated on the same edge as win_out.
- Aggregate combination: sum = modular sum of buckets; count = modular sum of bucket counts; max/min = signed reduction. An empty window yields identity.
- NUM_BUCKETS=1: pure tumbling window; every tick evicts the only bucket.
- Reset asserted mid-period: immediate return to reset state. Any pending win_valid is dropped.
- Aggregation is combinational over the buckets; registering the output bounds the critical path to one reduction tree.

Test Plan:
- Sum, NUM_BUCKETS=2, PERIOD_CYCLES=5. Samples 1,2,3 in period 0 → win_out=6, win_valid pulse 1 cycle after tick, win_full=0. Sample 4 in period 1 → 10, win_full=1. No samples in period 2 → 4 (period-0 bucket evicted).
- Simultaneous event: sample 5 on the tick cycle of an otherwise empty first period → win_out=5. The next period's bucket starts at 0.
- Max, MODE=2: samples -3, 7, 2 in one period → 7. Two empty periods later → -2^63 (identity).
- Count, MODE=1: 4 samples in period 0, 1 in period 1 → outputs 4 then 5. Sum wrap check: 2^63-1 plus 1 → -2^63.
- en low for 3 cycles mid-period → tick delayed by exactly 3 cycles; data_valid pulses during en=0 are not counted; win_valid is never high while en=0.
- Reset asserted asynchronously mid-period 1 (between edges) → outputs zero immediately. Restart with sample 9 → first win_out=9, win_full=0, bucket_idx=0 at restart.
